// File: rtl/stft_column_writer.sv
// Spectrogram column writer: turns a stream of complex FFT bins into 4-bit
// log-magnitude pixels and writes a decimated subset of frames into a
// circular buffer of NO_FFTS columns spread across NO_BANKS RAM banks.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   wr_en          high while a valid bin is presented (one run per frame)
//   idx            bin index of i_data
//   i_data         {signed real, signed imag}, WORD_WIDTH each
//   oldest_fft_idx column currently being (or next to be) written
//   disp_wr_en     RAM write strobe (selected frames only)
//   bank_wr        one-hot bank select
//   addr_wr        in-bank write address
//   data_wr        log2 magnitude, saturated to 15
module stft_column_writer #(
    parameter int unsigned COUNT_HIGH    = 20,
    parameter int unsigned FFT_SIZE      = 256,
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned NO_FFTS       = 50,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned NO_BANKS      = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [$clog2(FFT_SIZE/2)-1:0]      idx,
    input  logic [2*WORD_WIDTH-1:0]            i_data,
    output logic [$clog2(NO_FFTS)-1:0]         oldest_fft_idx,
    output logic                               disp_wr_en,
    output logic [NO_BANKS-1:0]                bank_wr,
    output logic [ADDRESS_WIDTH-1:0]           addr_wr,
    output logic [3:0]                         data_wr
);

    localparam int unsigned BINS  = FFT_SIZE / 2;
    localparam int unsigned COL_W = $clog2(NO_FFTS);
    localparam int unsigned CNT_W = (COUNT_HIGH > 1) ? $clog2(COUNT_HIGH) : 1;
    localparam int unsigned MW    = WORD_WIDTH + 1;
    localparam int unsigned LOG_W = $clog2(MW) + 1;

    logic [CNT_W-1:0] frame_cnt;
    logic             wr_en_d;
    logic             pulse_c;
    logic             count_true_c;

    logic [MW-1:0]    re_x_c, im_x_c, abs_re_c, abs_im_c, mag_c;
    logic [LOG_W-1:0] msb_c;
    logic [3:0]       log_c;
    logic [31:0]      lin_c;
    logic [31:0]      bank_idx_c;

    // End of frame is the falling edge of wr_en; frame 0 of each group is kept
    assign pulse_c      = !wr_en && wr_en_d;
    assign count_true_c = (frame_cnt == '0);

    // Frame counter, column pointer and wr_en history
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt      <= '0;
            wr_en_d        <= 1'b0;
            oldest_fft_idx <= '0;
        end else begin
            wr_en_d <= wr_en;
            if (pulse_c) begin
                if (frame_cnt == CNT_W'(COUNT_HIGH - 1))
                    frame_cnt <= '0;
                else
                    frame_cnt <= frame_cnt + CNT_W'(1);
                if (count_true_c) begin
                    if (oldest_fft_idx == COL_W'(NO_FFTS - 1))
                        oldest_fft_idx <= '0;
                    else
                        oldest_fft_idx <= oldest_fft_idx + COL_W'(1);
                end
            end
        end
    end

    // |re| + |im| in WORD_WIDTH+1 bits; sign-extend first so -2^(W-1) stays exact
    always_comb begin
        re_x_c   = {i_data[2*WORD_WIDTH-1], i_data[2*WORD_WIDTH-1:WORD_WIDTH]};
        im_x_c   = {i_data[WORD_WIDTH-1], i_data[WORD_WIDTH-1:0]};
        abs_re_c = re_x_c[MW-1] ? (~re_x_c + MW'(1)) : re_x_c;
        abs_im_c = im_x_c[MW-1] ? (~im_x_c + MW'(1)) : im_x_c;
        mag_c    = abs_re_c + abs_im_c;
    end

    // MSB position of the magnitude; bit 0 alone maps to 0 like mag==0
    always_comb begin
        msb_c = '0;
        for (int i = 1; i < int'(MW); i++) begin
            if (mag_c[i]) msb_c = LOG_W'(i);
        end
        log_c = (msb_c > LOG_W'(15)) ? 4'd15 : 4'(msb_c);
    end

    // Linear RAM address of this bin, split into bank and in-bank offset
    always_comb begin
        lin_c      = 32'(oldest_fft_idx) * 32'(BINS) + 32'(idx);
        bank_idx_c = lin_c >> ADDRESS_WIDTH;
    end

    // Write-side outputs, all aligned to the same input sample
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_wr_en <= 1'b0;
            bank_wr    <= '0;
            addr_wr    <= '0;
            data_wr    <= '0;
        end else begin
            disp_wr_en <= wr_en && count_true_c;
            bank_wr    <= NO_BANKS'(1) << bank_idx_c;
            addr_wr    <= ADDRESS_WIDTH'(lin_c);
            data_wr    <= log_c;
        end
    end

endmodule

// File: tb/tb_stft_column_writer.sv
// Directed bench for stft_column_writer with a cycle-level reference model
// and an expectation queue; explicit checks cover the documented corner cases.
module tb_stft_column_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [6:0]  idx;
    logic [31:0] i_data;
    logic [5:0]  oldest_fft_idx;
    logic        disp_wr_en;
    logic [1:0]  bank_wr;
    logic [11:0] addr_wr;
    logic [3:0]  data_wr;

    stft_column_writer dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .idx            (idx),
        .i_data         (i_data),
        .oldest_fft_idx (oldest_fft_idx),
        .disp_wr_en     (disp_wr_en),
        .bank_wr        (bank_wr),
        .addr_wr        (addr_wr),
        .data_wr        (data_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        disp;
        logic [1:0]  bank;
        logic [11:0] addr;
        logic [3:0]  data;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int n_writes = 0;

    // reference model state
    int m_cnt = 0;
    int m_ptr = 0;
    bit m_wd  = 1'b0;

    function automatic int exp_log(input logic [31:0] d);
        int re, im, m, n;
        re = int'($signed(d[31:16]));
        im = int'($signed(d[15:0]));
        m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        n  = 0;
        while (m > 1) begin
            m = m >> 1;
            n++;
        end
        return (n > 15) ? 15 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, queue the expectation, clock, model, then compare
    task automatic step(input logic r, input logic we, input logic [6:0] i, input logic [31:0] d);
        exp_t e;
        int   lin;
        bit   pulse;
        reset  = r;
        wr_en  = we;
        idx    = i;
        i_data = d;
        lin    = m_ptr * 128 + int'(i);
        e.disp = !r && we && (m_cnt == 0);
        e.bank = r ? 2'd0 : 2'(1 << (lin / 4096));
        e.addr = r ? 12'd0 : 12'(lin % 4096);
        e.data = r ? 4'd0 : 4'(exp_log(d));
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            m_cnt = 0;
            m_ptr = 0;
            m_wd  = 1'b0;
        end else begin
            pulse = !we && m_wd;
            if (pulse) begin
                if (m_cnt == 0) m_ptr = (m_ptr == 49) ? 0 : m_ptr + 1;
                m_cnt = (m_cnt == 19) ? 0 : m_cnt + 1;
            end
            m_wd = we;
        end
        #1;
        e = sb.pop_front();
        chk("disp_wr_en", 32'(disp_wr_en), 32'(e.disp));
        chk("bank_wr", 32'(bank_wr), 32'(e.bank));
        chk("addr_wr", 32'(addr_wr), 32'(e.addr));
        chk("data_wr", 32'(data_wr), 32'(e.data));
        chk("oldest_fft_idx", 32'(oldest_fft_idx), 32'(m_ptr));
        if (disp_wr_en === 1'b1) n_writes++;
    endtask

    task automatic send_frame(input int first, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 7'(first + k), $urandom);
        step(1'b0, 1'b0, 7'd0, $urandom);
    endtask

    // Short frames until the next frame is selected and lands in column col
    task automatic skip_to(input int col);
        int guard = 0;
        while (!(m_ptr == col && m_cnt == 0) && guard < 3000) begin
            send_frame(0, 1);
            guard++;
        end
        chk("skip_bound", 32'(guard < 3000), 32'd1);
    endtask

    logic [31:0] tbl[6]     = '{32'h0003_FFFC, 32'h0000_0000, 32'h0001_0000,
                                32'h7FFF_7FFF, 32'h8000_8000, 32'h0100_0000};
    logic [3:0]  tbl_exp[6] = '{4'd2, 4'd0, 4'd0, 4'd15, 4'd15, 4'd8};

    initial begin
        int w0;
        reset  = 1'b1;
        wr_en  = 1'b0;
        idx    = '0;
        i_data = '0;

        // reset state
        step(1'b1, 1'b0, 7'd0, 32'h0);
        step(1'b1, 1'b0, 7'd0, 32'h0);
        chk("rst_oldest", 32'(oldest_fft_idx), 32'd0);
        chk("rst_disp", 32'(disp_wr_en), 32'd0);
        chk("rst_bank", 32'(bank_wr), 32'd0);

        // first frame, column 0, with log-value table in the first bins
        for (int k = 0; k < 128; k++) begin
            step(1'b0, 1'b1, 7'(k), (k < 6) ? tbl[k] : $urandom);
            if (k < 6) chk("log_table", 32'(data_wr), 32'(tbl_exp[k]));
            if (k == 0) begin
                chk("f0_first_disp", 32'(disp_wr_en), 32'd1);
                chk("f0_first_bank", 32'(bank_wr), 32'd1);
                chk("f0_first_addr", 32'(addr_wr), 32'd0);
            end
            if (k == 127) begin
                chk("f0_last_bank", 32'(bank_wr), 32'd1);
                chk("f0_last_addr", 32'(addr_wr), 32'd127);
            end
        end
        step(1'b0, 1'b0, 7'd0, $urandom);
        chk("f0_ptr_after", 32'(oldest_fft_idx), 32'd1);
        chk("f0_writes", 32'(n_writes), 32'd128);

        // decimation: frames 1..40, only 20 and 40 are written
        w0 = n_writes;
        for (int f = 1; f <= 40; f++) send_frame(f % 128, 1);
        chk("decim_writes", 32'(n_writes - w0), 32'd2);
        chk("decim_ptr", 32'(oldest_fft_idx), 32'd3);

        // bank boundaries
        skip_to(31);
        step(1'b0, 1'b1, 7'd127, $urandom);
        chk("c31_bank", 32'(bank_wr), 32'd1);
        chk("c31_addr", 32'(addr_wr), 32'd4095);
        step(1'b0, 1'b0, 7'd0, $urandom);
        skip_to(32);
        step(1'b0, 1'b1, 7'd0, $urandom);
        chk("c32_bank", 32'(bank_wr), 32'd2);
        chk("c32_addr", 32'(addr_wr), 32'd0);
        step(1'b0, 1'b0, 7'd0, $urandom);
        skip_to(49);
        step(1'b0, 1'b1, 7'd127, $urandom);
        chk("c49_bank", 32'(bank_wr), 32'd2);
        chk("c49_addr", 32'(addr_wr), 32'd2303);
        step(1'b0, 1'b0, 7'd0, $urandom);
        chk("wrap_ptr", 32'(oldest_fft_idx), 32'd0);

        // 51st selected frame lands in column 0 again
        skip_to(0);
        for (int k = 0; k < 128; k++) begin
            step(1'b0, 1'b1, 7'(k), $urandom);
            if (k == 0) begin
                chk("wrap_first_bank", 32'(bank_wr), 32'd1);
                chk("wrap_first_addr", 32'(addr_wr), 32'd0);
            end
            if (k == 127) chk("wrap_last_addr", 32'(addr_wr), 32'd127);
        end
        step(1'b0, 1'b0, 7'd0, $urandom);

        // reset in the middle of a frame at column 5
        skip_to(5);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 7'(k), $urandom);
        step(1'b1, 1'b1, 7'd10, $urandom);
        chk("mr_disp", 32'(disp_wr_en), 32'd0);
        chk("mr_bank", 32'(bank_wr), 32'd0);
        chk("mr_addr", 32'(addr_wr), 32'd0);
        chk("mr_data", 32'(data_wr), 32'd0);
        chk("mr_ptr", 32'(oldest_fft_idx), 32'd0);
        for (int k = 11; k < 128; k++) begin
            step(1'b0, 1'b1, 7'(k), $urandom);
            if (k == 11) begin
                chk("mr_resume_disp", 32'(disp_wr_en), 32'd1);
                chk("mr_resume_bank", 32'(bank_wr), 32'd1);
                chk("mr_resume_addr", 32'(addr_wr), 32'd11);
            end
        end
        step(1'b0, 1'b0, 7'd0, $urandom);
        chk("mr_ptr_after", 32'(oldest_fft_idx), 32'd1);

        step(1'b0, 1'b0, 7'd0, $urandom);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
